clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Receive-side companion to the toggle clock divider. Samples a divided clock
//  (div_clk_in) in the fast clk_in domain and emits one-cycle rise/fall strobes.
//  Measures each half-period in clk_in cycles and declares lock/loss against an
//  expected ratio. Sits beside every divider output for enable generation and health checks.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops on div_clk_in (min 2; 0 illegal)
//  CNT_W        16  width of half-period counter/measurement
//  EXP_HALF     1   expected half-period in clk_in cycles (1 = divide-by-2)
//  TOL          0   allowed |measured-EXP_HALF| deviation
//  LOCK_CNT     4   consecutive good half-periods needed to lock (>=1)
//  TIMEOUT      64  clk_in cycles with no edge that count as clock loss (>EXP_HALF+TOL)
// PORTS
//  clk_in       in   1      fast reference clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  div_clk_in   in   1      divided clock under observation (async to clk_in allowed)
//  rise_pulse   out  1      one-cycle strobe per synchronized rising edge
//  fall_pulse   out  1      one-cycle strobe per synchronized falling edge
//  half_period  out  CNT_W  last measured half-period, clk_in cycles
//  period_valid out  1      one-cycle strobe: half_period just updated
//  locked       out  1      high in LOCKED state
//  lost         out  1      high in LOST state
//  err_cnt      out  8      count of bad half-periods/timeouts, saturates at 255
// BEHAVIOUR
//  Reset (rst_n=0, async): sync chain, prev, hcnt, good_cnt, all outputs = 0; state=SEARCH.
//  Edge detect: edge = sync_out ^ prev. All outputs registered; a level change on
//   div_clk_in gives its strobe SYNC_STAGES+1 clk_in rising edges after first sampling it.
//  hcnt: cleared to 0 on an edge cycle, else +1, saturating at all-ones.
//  Measurement on edge: meas = hcnt+1 (saturate all-ones); half_period<=meas,
//   period_valid=1 same cycle as rise/fall_pulse. Toggle-every-cycle input -> meas=1.
//  good = |meas-EXP_HALF| <= TOL (unsigned compare, no wrap). timeout = !edge && hcnt==TIMEOUT-1.
//  FSM (clk_mon_pkg::state_t):
//   SEARCH : edge -> ACQUIRE, good_cnt=0 (first measurement discarded, not an error).
//   ACQUIRE: edge&good -> good_cnt+1; reaching LOCK_CNT -> LOCKED.
//            edge&!good -> good_cnt=0, err_cnt+1, stay. timeout -> SEARCH, err_cnt+1.
//   LOCKED : edge&!good -> LOST, err_cnt+1. timeout -> LOST, err_cnt+1. good edges: stay.
//   LOST   : edge -> ACQUIRE, good_cnt=0 (measurement discarded). timeout: stay, no count.
//  Simultaneous edge and hcnt limit: edge wins (timeout requires no edge).
//  locked/lost registered from next state; update in same cycle as triggering strobe.
//  err_cnt saturates at 8'hFF, never wraps; cleared only by rst_n.
//  Reset mid-operation: all state cleared immediately; no strobe generated by the
//   sync chain refilling after reset unless div_clk_in is high (rise then reported, discarded in SEARCH).
// STRUCTURE
//  clk_mon_pkg: state_t {SEARCH,ACQUIRE,LOCKED,LOST}, ERR_W=8, ERR_MAX constant.
//  Sub-module sync_edge_det (SYNC_STAGES flops + prev reg, outputs rise/fall/edge);
//  top holds hcnt, measurement compare, FSM, err_cnt.
// TESTING (SYNC_STAGES=2, EXP_HALF=4, TOL=0, LOCK_CNT=4, TIMEOUT=32 unless noted)
//  1 Hold rst_n=0, toggle clk_in -> all outputs 0; release with div_clk_in=0 -> no strobes.
//  2 div_clk_in toggles every 4 clk_in -> half_period=4 each strobe; locked=1 on 5th edge strobe.
//  3 While locked, one half-period of 6 -> lost=1, locked=0, err_cnt=1; resume 4s -> locked on 5th edge.
//  4 While locked, hold div_clk_in static -> lost=1 exactly 32 cycles after last edge strobe, err_cnt+1.
//  5 EXP_HALF=1, div_clk_in toggling every clk_in -> half_period=1, rise/fall alternate, locked after 5 edges.
//  6 Assert rst_n mid-LOCKED with err_cnt=3 -> locked, err_cnt, half_period cleared same cycle, async.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state encoding and error-counter constants for clk_div_monitor
package clk_mon_pkg;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, LOST} state_t;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronizes an async level into clk_in and flags its edges
//   clk_in   in  fast sampling clock
//   rst_n    in  async active-low reset
//   din      in  async level to observe
//   rise     out combinational: synchronized level went 0->1
//   fall     out combinational: synchronized level went 1->0
//   edge_det out combinational: rise | fall
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic edge_det
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end
    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev;
    assign rise     = edge_det & sync_q[SYNC_STAGES-1];
    assign fall     = edge_det & prev;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures half-periods of a divided clock and tracks lock/loss
//   clk_in       in  fast reference clock
//   rst_n        in  async active-low reset
//   div_clk_in   in  divided clock under observation
//   rise_pulse   out one-cycle strobe per synchronized rising edge
//   fall_pulse   out one-cycle strobe per synchronized falling edge
//   half_period  out last measured half-period in clk_in cycles
//   period_valid out one-cycle strobe: half_period just updated
//   locked       out high while LOCKED
//   lost         out high while LOST
//   err_cnt      out saturating count of bad half-periods and timeouts
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EXP_HALF    = 1,
    parameter int TOL         = 0,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] EXP_V = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT - 1);
    logic rise, fall, edge_det, good, timeout, err_inc;
    logic [CNT_W-1:0] hcnt, meas, diff;
    logic [GW-1:0] good_cnt, good_nx;
    state_t state, state_nx;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .din      (div_clk_in),
        .rise     (rise),
        .fall     (fall),
        .edge_det (edge_det)
    );
    // meas doubles as the saturating increment of hcnt
    assign meas    = &hcnt ? hcnt : hcnt + 1'b1;
    assign diff    = meas > EXP_V ? meas - EXP_V : EXP_V - meas;
    assign good    = diff <= TOL_V;
    assign timeout = !edge_det && hcnt == TO_V;
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_inc  = 1'b0;
        case (state)
            SEARCH: begin
                state_nx = edge_det ? ACQUIRE : SEARCH;
                good_nx  = '0;
            end
            ACQUIRE: begin
                if (edge_det && good) begin
                    good_nx  = good_cnt + 1'b1;
                    state_nx = good_cnt == GW'(LOCK_CNT - 1) ? LOCKED : ACQUIRE;
                end else if (edge_det) begin
                    good_nx = '0;
                    err_inc = 1'b1;
                end else if (timeout) begin
                    state_nx = SEARCH;
                    err_inc  = 1'b1;
                end
            end
            LOCKED: begin
                err_inc  = (edge_det && !good) || timeout;
                state_nx = err_inc ? LOST : LOCKED;
            end
            LOST: begin
                state_nx = edge_det ? ACQUIRE : LOST;
                good_nx  = '0;
            end
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcnt         <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= '0;
            state        <= SEARCH;
            good_cnt     <= '0;
            locked       <= 1'b0;
            lost         <= 1'b0;
            err_cnt      <= '0;
        end else begin
            hcnt         <= edge_det ? '0 : meas;
            rise_pulse   <= rise;
            fall_pulse   <= fall;
            period_valid <= edge_det;
            half_period  <= edge_det ? meas : half_period;
            state        <= state_nx;
            good_cnt     <= good_nx;
            locked       <= state_nx == LOCKED;
            lost         <= state_nx == LOST;
            err_cnt      <= (err_inc && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: self-checking bench for two clk_div_monitor configurations
module tb_clk_div_monitor;
    localparam int TO   = 32;
    localparam int TOLV = 0;
    localparam int LCK  = 4;
    logic clk_in = 1'b0, rst_n = 1'b0, div0 = 1'b0, div1 = 1'b0;
    logic r0, f0, pv0, l0, lo0, r1, f1, pv1, l1, lo1;
    logic [15:0] hp0, hp1;
    logic [7:0] e0, e1;
    int n_chk = 0, n_fail = 0;
    always #5 clk_in = ~clk_in;
    clk_div_monitor #(.SYNC_STAGES(2), .CNT_W(16), .EXP_HALF(4), .TOL(0), .LOCK_CNT(4), .TIMEOUT(32)) dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .div_clk_in(div0), .rise_pulse(r0), .fall_pulse(f0),
        .half_period(hp0), .period_valid(pv0), .locked(l0), .lost(lo0), .err_cnt(e0));
    clk_div_monitor #(.SYNC_STAGES(2), .CNT_W(16), .EXP_HALF(1), .TOL(0), .LOCK_CNT(4), .TIMEOUT(32)) dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .div_clk_in(div1), .rise_pulse(r1), .fall_pulse(f1),
        .half_period(hp1), .period_valid(pv1), .locked(l1), .lost(lo1), .err_cnt(e1));
    // Reference model: smp[i][k] is the input seen at the k-th clock after reset;
    // the monitor reports a level change two samples late, measured as the
    // distance in clocks from the previous reported change.
    int kk;
    bit smp[2][0:4095];
    int last[2], mode[2], gc[2], ec[2], hp[2];
    bit xr[2], xf[2], xpv[2];
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            kk <= 0;
            for (int i = 0; i < 2; i++) begin
                last[i] <= 0; mode[i] <= 0; gc[i] <= 0; ec[i] <= 0; hp[i] <= 0;
                xr[i] <= 1'b0; xf[i] <= 1'b0; xpv[i] <= 1'b0;
            end
        end else begin
            kk <= kk + 1;
            for (int i = 0; i < 2; i++) begin
                int k, meas, nm, ngc, ex, dv;
                bit e, now, old, good, to, bad;
                k    = kk + 1;
                ex   = (i == 0) ? 4 : 1;
                now  = (k >= 3) ? smp[i][k-2] : 1'b0;
                old  = (k >= 4) ? smp[i][k-3] : 1'b0;
                e    = now != old;
                meas = (k - last[i] > 65535) ? 65535 : k - last[i];
                dv   = meas > ex ? meas - ex : ex - meas;
                good = dv <= TOLV;
                to   = !e && (k - last[i]) == TO;
                nm   = mode[i];
                ngc  = gc[i];
                bad  = 1'b0;
                case (mode[i])
                    0: if (e) begin nm = 1; ngc = 0; end
                    1: if (e && good) begin ngc = gc[i] + 1; if (ngc == LCK) nm = 2; end
                       else if (e) begin ngc = 0; bad = 1'b1; end
                       else if (to) begin nm = 0; bad = 1'b1; end
                    2: if ((e && !good) || to) begin nm = 3; bad = 1'b1; end
                    default: if (e) begin nm = 1; ngc = 0; end
                endcase
                mode[i] <= nm;
                gc[i]   <= ngc;
                ec[i]   <= (bad && ec[i] < 255) ? ec[i] + 1 : ec[i];
                xr[i]   <= e && now;
                xf[i]   <= e && !now;
                xpv[i]  <= e;
                if (e) begin hp[i] <= meas; last[i] <= k; end
                if (k < 4096) smp[i][k] <= (i == 0) ? div0 : div1;
            end
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic check_all();
        chk("rise0", 32'(r0), 32'(xr[0]));   chk("rise1", 32'(r1), 32'(xr[1]));
        chk("fall0", 32'(f0), 32'(xf[0]));   chk("fall1", 32'(f1), 32'(xf[1]));
        chk("pv0", 32'(pv0), 32'(xpv[0]));   chk("pv1", 32'(pv1), 32'(xpv[1]));
        chk("hp0", 32'(hp0), hp[0]);         chk("hp1", 32'(hp1), hp[1]);
        chk("locked0", 32'(l0), 32'(mode[0] == 2)); chk("locked1", 32'(l1), 32'(mode[1] == 2));
        chk("lost0", 32'(lo0), 32'(mode[0] == 3));  chk("lost1", 32'(lo1), 32'(mode[1] == 3));
        chk("err0", 32'(e0), ec[0]);         chk("err1", 32'(e1), ec[1]);
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check_all();
        end
    endtask
    task automatic half0(input int n);
        div0 = ~div0;
        cyc(n);
    endtask
    initial begin
        int c0;
        repeat (3) @(negedge clk_in);
        check_all();
        chk("rst_locked", 32'(l0), 0);
        chk("rst_err", 32'(e0), 0);
        rst_n = 1'b1;
        cyc(6);
        chk("idle_rise", 32'(r0 | f0 | pv0), 0);
        for (int t = 1; t <= 7; t++) begin
            half0(4);
            if (t >= 2) chk("t2_hp", 32'(hp0), 4);
            if (t == 4) chk("t2_not_yet", 32'(l0), 0);
            if (t == 5) chk("t2_locked", 32'(l0), 1);
        end
        half0(6);
        half0(4);
        chk("t3_lost", 32'(lo0), 1);
        chk("t3_unlocked", 32'(l0), 0);
        chk("t3_err", 32'(e0), 1);
        chk("t3_hp", 32'(hp0), 6);
        for (int t = 1; t <= 5; t++) begin
            half0(4);
            if (t == 4) chk("t3_not_yet", 32'(l0), 0);
            if (t == 5) chk("t3_relock", 32'(l0), 1);
        end
        cyc(30);
        chk("t4_before_to", 32'(lo0), 0);
        cyc(1);
        chk("t4_lost", 32'(lo0), 1);
        chk("t4_err", 32'(e0), 2);
        for (int t = 1; t <= 5; t++) half0(4);
        chk("t4_relock", 32'(l0), 1);
        half0(6);
        half0(4);
        chk("t6_err_prep", 32'(e0), 3);
        for (int t = 1; t <= 5; t++) half0(4);
        chk("t6_locked", 32'(l0), 1);
        chk("t6_err3", 32'(e0), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_locked", 32'(l0), 0);
        chk("t6_async_err", 32'(e0), 0);
        chk("t6_async_hp", 32'(hp0), 0);
        check_all();
        @(negedge clk_in);
        check_all();
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            div1 = ~div1;
            cyc(1);
            if (t >= 3) chk("t5_strobe", 32'(r1 ^ f1), 1);
            if (t == 6) chk("t5_not_yet", 32'(l1), 0);
            if (t == 7) chk("t5_locked", 32'(l1), 1);
        end
        chk("t5_hp", 32'(hp1), 1);
        c0 = 4;
        repeat (800) begin
            c0--;
            if (c0 == 0) begin
                div0 = ~div0;
                case ($urandom_range(0, 9))
                    0: c0 = 40;
                    1: c0 = 6;
                    2: c0 = 3;
                    default: c0 = 4;
                endcase
            end
            if ($urandom_range(0, 3) != 0) div1 = ~div1;
            cyc(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
